// File: rtl/nx_ram_2rw_arb.sv
// Round-robin arbiter/sequencer sharing both ports of one nx_ram_2rw among NUM_REQ requesters.
// Define NX_RAM_ARB_INIT_EN to zero-fill the RAM after reset before accepting requests.
module nx_ram_2rw_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned RAM_LAT = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic                     rsp_a_vld,
  output logic [IW-1:0]            rsp_a_id,
  output logic [WIDTH-1:0]         rsp_a_data,
  output logic                     rsp_b_vld,
  output logic [IW-1:0]            rsp_b_id,
  output logic [WIDTH-1:0]         rsp_b_data,
  output logic                     init_done,
  output logic                     csa,
  output logic                     wea,
  output logic                     csb,
  output logic                     web,
  output logic [AW-1:0]            adda,
  output logic [AW-1:0]            addb,
  output logic [WIDTH-1:0]         dina,
  output logic [WIDTH-1:0]         dinb,
  output logic [WIDTH-1:0]         bwea,
  output logic [WIDTH-1:0]         bweb,
  input  logic [WIDTH-1:0]         douta,
  input  logic [WIDTH-1:0]         doutb
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          run;

  logic [RAM_LAT-1:0]         a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [RAM_LAT-1:0][IW-1:0] a_id_q, a_id_d, b_id_q, b_id_d;

  logic [AW-1:0]    addr_arr  [NUM_REQ];
  logic [WIDTH-1:0] wdata_arr [NUM_REQ];

  logic          g0_vld, g1_hit, g1_vld;
  logic [IW-1:0] g0, g1;
  logic [IW:0]   idx;
  logic [IW:0]   nxt;

`ifdef NX_RAM_ARB_INIT_EN
  localparam int unsigned CW = AW + 2;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign run = (state_q == ST_RUN);

  // Unpack the flat request buses
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Pick the first two valid requesters in rotating order starting at ptr
  always_comb begin
    g0_vld = 1'b0;
    g1_hit = 1'b0;
    g0     = '0;
    g1     = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (run && req_vld[idx[IW-1:0]]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = idx[IW-1:0];
        end else if (!g1_hit) begin
          g1_hit = 1'b1;
          g1     = idx[IW-1:0];
        end
      end
    end
    g1_vld = g1_hit && !((addr_arr[g0] == addr_arr[g1]) && (req_wr[g0] || req_wr[g1]));
  end

  // Pointer advances past the last granted requester
  always_comb begin
    ptr_d = ptr_q;
    nxt   = {1'b0, (g1_vld ? g1 : g0)} + (IW+1)'(1);
    if (nxt == (IW+1)'(NUM_REQ)) nxt = '0;
    if (g0_vld) ptr_d = nxt[IW-1:0];
  end

  // FSM next state and RAM port drive
  always_comb begin
    state_d = state_q;
    req_rdy = '0;
    csa     = 1'b0;
    wea     = 1'b0;
    adda    = '0;
    dina    = '0;
    csb     = 1'b0;
    web     = 1'b0;
    addb    = '0;
    dinb    = '0;
`ifdef NX_RAM_ARB_INIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef NX_RAM_ARB_INIT_EN
        csa   = 1'b1;
        wea   = 1'b1;
        adda  = cnt_q[AW-1:0];
        csb   = (cnt_q + CW'(1)) < CW'(DEPTH);
        web   = csb;
        addb  = AW'(cnt_q + CW'(1));
        cnt_d = cnt_q + CW'(2);
        if ((cnt_q + CW'(2)) >= CW'(DEPTH)) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      default: begin
        if (g0_vld) begin
          req_rdy[g0] = 1'b1;
          csa         = 1'b1;
          wea         = req_wr[g0];
          adda        = addr_arr[g0];
          dina        = wdata_arr[g0];
        end
        if (g1_vld) begin
          req_rdy[g1] = 1'b1;
          csb         = 1'b1;
          web         = req_wr[g1];
          addb        = addr_arr[g1];
          dinb        = wdata_arr[g1];
        end
      end
    endcase
  end

  // Read-return tracking: one {vld,id} stage per cycle of RAM latency
  always_comb begin
    a_vld_d    = '0;
    b_vld_d    = '0;
    a_id_d     = '0;
    b_id_d     = '0;
    a_vld_d[0] = g0_vld && !req_wr[g0];
    a_id_d[0]  = g0;
    b_vld_d[0] = g1_vld && !req_wr[g1];
    b_id_d[0]  = g1;
    for (int i = 1; i < RAM_LAT; i++) begin
      a_vld_d[i] = a_vld_q[i-1];
      a_id_d[i]  = a_id_q[i-1];
      b_vld_d[i] = b_vld_q[i-1];
      b_id_d[i]  = b_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      a_vld_q <= '0;
      a_id_q  <= '0;
      b_vld_q <= '0;
      b_id_q  <= '0;
`ifdef NX_RAM_ARB_INIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_vld_q <= a_vld_d;
      a_id_q  <= a_id_d;
      b_vld_q <= b_vld_d;
      b_id_q  <= b_id_d;
`ifdef NX_RAM_ARB_INIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign init_done  = state_q;
  assign rsp_a_vld  = a_vld_q[RAM_LAT-1];
  assign rsp_a_id   = a_id_q[RAM_LAT-1];
  assign rsp_a_data = douta;
  assign rsp_b_vld  = b_vld_q[RAM_LAT-1];
  assign rsp_b_id   = b_id_q[RAM_LAT-1];
  assign rsp_b_data = doutb;
  assign bwea       = {WIDTH{1'b1}};
  assign bweb       = {WIDTH{1'b1}};

endmodule

// File: tb/tb_nx_ram_2rw_arb.sv
// Randomized bench for nx_ram_2rw_arb with a behavioural RAM and a grant/response reference model.
module tb_nx_ram_2rw_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 64;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned RAM_LAT = 2;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned IW      = $clog2(NUM_REQ);
  localparam int unsigned MAXC    = 8192;
`ifdef NX_RAM_ARB_INIT_EN
  localparam int unsigned INIT_CYC = (DEPTH + 1) / 2;
`else
  localparam int unsigned INIT_CYC = 1;
`endif

  logic                     clk, rst_n;
  logic [NUM_REQ-1:0]       req_vld, req_wr, req_rdy;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic                     rsp_a_vld, rsp_b_vld, init_done;
  logic [IW-1:0]            rsp_a_id, rsp_b_id;
  logic [WIDTH-1:0]         rsp_a_data, rsp_b_data;
  logic                     csa, wea, csb, web;
  logic [AW-1:0]            adda, addb;
  logic [WIDTH-1:0]         dina, dinb, bwea, bweb, douta, doutb;

  nx_ram_2rw_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdy(req_rdy), .rsp_a_vld(rsp_a_vld), .rsp_a_id(rsp_a_id),
    .rsp_a_data(rsp_a_data), .rsp_b_vld(rsp_b_vld), .rsp_b_id(rsp_b_id), .rsp_b_data(rsp_b_data),
    .init_done(init_done), .csa(csa), .wea(wea), .csb(csb), .web(web), .adda(adda), .addb(addb),
    .dina(dina), .dinb(dinb), .bwea(bwea), .bweb(bweb), .douta(douta), .doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with RAM_LAT read latency
  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] pa  [RAM_LAT];
  logic [WIDTH-1:0] pb  [RAM_LAT];
  always @(posedge clk) begin
    if (csa && wea) ram[adda] <= (ram[adda] & ~bwea) | (dina & bwea);
    if (csb && web) ram[addb] <= (ram[addb] & ~bweb) | (dinb & bweb);
    pa[0] <= (csa && !wea) ? ram[adda] : '0;
    pb[0] <= (csb && !web) ? ram[addb] : '0;
    for (int i = 1; i < RAM_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign douta = pa[RAM_LAT-1];
  assign doutb = pb[RAM_LAT-1];

  int checks, errors, cyc, ptr, init_left, init_idx;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               known   [DEPTH];
  bit               ea_v [MAXC];
  bit               ea_k [MAXC];
  int               ea_id[MAXC];
  logic [WIDTH-1:0] ea_d [MAXC];
  bit               eb_v [MAXC];
  bit               eb_k [MAXC];
  int               eb_id[MAXC];
  logic [WIDTH-1:0] eb_d [MAXC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int r);
    return req_addr[r*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] data_of(input int r);
    return req_wdata[r*WIDTH +: WIDTH];
  endfunction

  // Apply one accepted access to the reference memory / response schedule
  task automatic commit(input int r, input bit port_b);
    int due;
    logic [AW-1:0] a;
    due = cyc + int'(RAM_LAT);
    a = addr_of(r);
    if (req_wr[r]) begin
      ref_mem[a] = data_of(r);
      known[a] = 1'b1;
    end else if (due < int'(MAXC)) begin
      if (!port_b) begin
        ea_v[due] = 1'b1; ea_id[due] = r; ea_d[due] = ref_mem[a]; ea_k[due] = known[a];
      end else begin
        eb_v[due] = 1'b1; eb_id[due] = r; eb_d[due] = ref_mem[a]; eb_k[due] = known[a];
      end
    end
  endtask

  // Check one cycle of DUT behaviour against the model, then advance the model
  task automatic step();
    int sel [2];
    int n;
    int r;
    bit ga, gb;
    logic [NUM_REQ-1:0] erdy;
    chk("rsp_a_vld", 64'(rsp_a_vld), 64'(ea_v[cyc]));
    if (ea_v[cyc]) begin
      chk("rsp_a_id", 64'(rsp_a_id), 64'(ea_id[cyc]));
      if (ea_k[cyc]) chk("rsp_a_data", rsp_a_data, ea_d[cyc]);
    end
    chk("rsp_b_vld", 64'(rsp_b_vld), 64'(eb_v[cyc]));
    if (eb_v[cyc]) begin
      chk("rsp_b_id", 64'(rsp_b_id), 64'(eb_id[cyc]));
      if (eb_k[cyc]) chk("rsp_b_data", rsp_b_data, eb_d[cyc]);
    end
    if (init_left > 0) begin
      chk("init_done_lo", 64'(init_done), 64'(0));
      chk("init_rdy", 64'(req_rdy), 64'(0));
`ifdef NX_RAM_ARB_INIT_EN
      chk("init_csa", 64'(csa), 64'(1));
      chk("init_wea", 64'(wea), 64'(1));
      chk("init_adda", 64'(adda), 64'(2*init_idx));
      chk("init_dina", dina, 64'(0));
      chk("init_csb", 64'(csb), 64'((2*init_idx + 1) < int'(DEPTH)));
      if ((2*init_idx + 1) < int'(DEPTH)) begin
        chk("init_web", 64'(web), 64'(1));
        chk("init_addb", 64'(addb), 64'(2*init_idx + 1));
        chk("init_dinb", dinb, 64'(0));
      end
`else
      chk("init_csa", 64'(csa), 64'(0));
      chk("init_csb", 64'(csb), 64'(0));
`endif
      init_left--;
      init_idx++;
    end else begin
      chk("init_done_hi", 64'(init_done), 64'(1));
      n = 0;
      sel[0] = 0;
      sel[1] = 0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r = (ptr + k) % int'(NUM_REQ);
        if (req_vld[r] && n < 2) begin
          sel[n] = r;
          n++;
        end
      end
      ga = (n >= 1);
      gb = (n == 2) && !((addr_of(sel[0]) == addr_of(sel[1])) && (req_wr[sel[0]] || req_wr[sel[1]]));
      erdy = '0;
      if (ga) erdy[sel[0]] = 1'b1;
      if (gb) erdy[sel[1]] = 1'b1;
      chk("req_rdy", 64'(req_rdy), 64'(erdy));
      chk("csa", 64'(csa), 64'(ga));
      chk("csb", 64'(csb), 64'(gb));
      if (ga) begin
        chk("wea", 64'(wea), 64'(req_wr[sel[0]]));
        chk("adda", 64'(adda), 64'(addr_of(sel[0])));
        if (req_wr[sel[0]]) chk("dina", dina, data_of(sel[0]));
        commit(sel[0], 1'b0);
      end
      if (gb) begin
        chk("web", 64'(web), 64'(req_wr[sel[1]]));
        chk("addb", 64'(addb), 64'(addr_of(sel[1])));
        if (req_wr[sel[1]]) chk("dinb", dinb, data_of(sel[1]));
        commit(sel[1], 1'b1);
      end
      if (ga) ptr = ((gb ? sel[1] : sel[0]) + 1) % int'(NUM_REQ);
    end
    cyc++;
  endtask

  task automatic cycle(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] w,
                       input logic [NUM_REQ*AW-1:0] a, input logic [NUM_REQ*WIDTH-1:0] d);
    req_vld = v; req_wr = w; req_addr = a; req_wdata = d;
    #1;
    step();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle('0, '0, '0, '0);
  endtask

  task automatic rand_cycle();
    logic [NUM_REQ*AW-1:0]    a;
    logic [NUM_REQ*WIDTH-1:0] d;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      a[i*AW +: AW]       = AW'($urandom_range(0, 15));
      d[i*WIDTH +: WIDTH] = {$urandom, $urandom};
    end
    cycle(NUM_REQ'($urandom), NUM_REQ'($urandom), a, d);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int c = cyc; c < int'(MAXC); c++) begin
      ea_v[c] = 1'b0;
      eb_v[c] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_rsp_a_vld", 64'(rsp_a_vld), 64'(0));
      chk("rst_rsp_b_vld", 64'(rsp_b_vld), 64'(0));
      chk("rst_rsp_a_id", 64'(rsp_a_id), 64'(0));
      chk("rst_req_rdy", 64'(req_rdy), 64'(0));
      chk("rst_init_done", 64'(init_done), 64'(0));
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    ptr = 0;
    init_left = int'(INIT_CYC);
    init_idx = 0;
`ifdef NX_RAM_ARB_INIT_EN
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = '0;
      known[i] = 1'b1;
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_REQ*AW-1:0]    a;
    logic [NUM_REQ*WIDTH-1:0] d;
    int share [NUM_REQ];
    checks = 0; errors = 0; cyc = 0; ptr = 0; init_left = 0; init_idx = 0;
    rst_n = 1'b0;
    req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = '0;
      known[i] = 1'b0;
    end
    @(negedge clk);
    do_reset(3);
    while (init_left > 0) idle();
    idle();

    // All requesters reading continuously from ptr=0: pairs (0,1),(2,3),...
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      share[i] = 0;
      a[i*AW +: AW] = AW'(3*i + 37);
    end
    for (int c = 0; c < 16; c++) begin
      req_vld = '1; req_wr = '0; req_addr = a; req_wdata = '0;
      #1;
      for (int i = 0; i < int'(NUM_REQ); i++) share[i] += int'(req_rdy[i]);
      step();
      @(negedge clk);
    end
    for (int i = 0; i < int'(NUM_REQ); i++) chk("rr_share", 64'(share[i]), 64'(8));
    repeat (RAM_LAT) idle();

    // Write/read conflict on one address: only the write goes first
    a = '0;
    a[0*AW +: AW] = AW'(5);
    a[1*AW +: AW] = AW'(5);
    d = '0;
    d[0*WIDTH +: WIDTH] = 64'h0123_4567_89ab_cdef;
    cycle(4'b0011, 4'b0001, a, d);
    cycle(4'b0010, 4'b0000, a, d);
    repeat (RAM_LAT) idle();

    // Single requester 2: write 0xA5 @10 then read it back
    a = '0;
    a[2*AW +: AW] = AW'(10);
    d = '0;
    d[2*WIDTH +: WIDTH] = 64'hA5;
    cycle(4'b0100, 4'b0100, a, d);
    cycle(4'b0100, 4'b0000, a, d);
    repeat (RAM_LAT) idle();

    repeat (1500) rand_cycle();
    repeat (RAM_LAT) idle();

    // Reads in flight on both ports, then reset: they must never respond
    a = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) a[i*AW +: AW] = AW'(i);
    cycle('1, '0, a, '0);
    cycle('1, '0, a, '0);
    do_reset(2);
    while (init_left > 0) idle();
    repeat (RAM_LAT + 2) idle();

    repeat (300) rand_cycle();
    repeat (RAM_LAT + 1) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
